// File: rtl/led_ram_wr_sched.sv
// Write-port scheduler for the 8x8 LED display RAM. It arbitrates the single write
// port between the sweep engine, the light pen and the host, in that priority order.
module led_ram_wr_sched #(
  parameter int              DATA_W      = 4,
  parameter int              IDX_W       = 3,
  parameter logic [DATA_W-1:0] OP_INV_MASK = 4'b1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pen_we,
  input  logic [IDX_W-1:0]  pen_row,
  input  logic [IDX_W-1:0]  pen_col,
  input  logic [DATA_W-1:0] pen_data,
  input  logic              host_req,
  input  logic [IDX_W-1:0]  host_row,
  input  logic [IDX_W-1:0]  host_col,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              pen_drop,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [IDX_W-1:0]  ram_row,
  output logic [IDX_W-1:0]  ram_col,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        dbg_state
);

  // Handshakes: a command is accepted when cmd_valid && cmd_ready; a host write
  // is performed in exactly the cycle host_ack is high, and host_req is held until then.

  localparam int CNT_W = 2 * IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [1:0]         op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    data_d     = data_q;
    cmd_ready  = 1'b0;
    sweep_busy = 1'b0;
    sweep_done = 1'b0;
    pen_drop   = 1'b0;
    host_ack   = 1'b0;
    ram_we     = 1'b0;
    ram_row    = '0;
    ram_col    = '0;
    ram_wdata  = '0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = (cmd_op == OP_RSVD) ? ST_DONE : ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        sweep_busy = 1'b1;
        ram_we     = 1'b1;
        ram_row    = idx_q[CNT_W-1:IDX_W];
        ram_col    = idx_q[IDX_W-1:0];
        case (op_q)
          OP_CLEAR: ram_wdata = '0;
          OP_FILL:  ram_wdata = data_q;
          // Invert is a same-cycle read-modify-write through the async read port.
          default:  ram_wdata = ram_rdata ^ OP_INV_MASK;
        endcase
        pen_drop = pen_we;
        if (idx_q == {CNT_W{1'b1}}) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        sweep_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_SWEEP) begin
      if (pen_we) begin
        ram_we    = 1'b1;
        ram_row   = pen_row;
        ram_col   = pen_col;
        ram_wdata = pen_data;
      end else if (host_req) begin
        host_ack  = 1'b1;
        ram_we    = 1'b1;
        ram_row   = host_row;
        ram_col   = host_col;
        ram_wdata = host_data;
      end
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_ram_wr_sched.sv
// Directed bench for led_ram_wr_sched with a behavioural 8x8 RAM model attached
// to the write port and the asynchronous read port.
module tb_led_ram_wr_sched;

  logic       clk;
  logic       rst_n;
  logic       pen_we;
  logic [2:0] pen_row, pen_col;
  logic [3:0] pen_data;
  logic       host_req;
  logic [2:0] host_row, host_col;
  logic [3:0] host_data;
  logic       host_ack;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_ready, sweep_busy, sweep_done, pen_drop;
  logic [3:0] ram_rdata;
  logic       ram_we;
  logic [2:0] ram_row, ram_col;
  logic [3:0] ram_wdata;
  logic [1:0] dbg_state;

  logic [3:0] ram_mem [64] = '{default: 4'h0};
  logic [3:0] snap [64];
  logic [9:0] exp_q [$];
  logic [9:0] exp_w;

  int n_checks = 0;
  int n_errors = 0;
  int bad;
  int cnt;

  led_ram_wr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .pen_we(pen_we), .pen_row(pen_row), .pen_col(pen_col), .pen_data(pen_data),
    .host_req(host_req), .host_row(host_row), .host_col(host_col),
    .host_data(host_data), .host_ack(host_ack),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .pen_drop(pen_drop), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .ram_row(ram_row), .ram_col(ram_col), .ram_wdata(ram_wdata),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign ram_rdata = ram_mem[{ram_row, ram_col}];

  always @(posedge clk) begin
    if (ram_we) ram_mem[{ram_row, ram_col}] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pen(input logic we, input logic [2:0] r, input logic [2:0] c,
                         input logic [3:0] d);
    pen_we = we; pen_row = r; pen_col = c; pen_data = d;
  endtask

  task automatic set_host(input logic req, input logic [2:0] r, input logic [2:0] c,
                          input logic [3:0] d);
    host_req = req; host_row = r; host_col = c; host_data = d;
  endtask

  initial begin
    rst_n = 1'b1;
    set_pen(1'b0, 3'd0, 3'd0, 4'h0);
    set_host(1'b0, 3'd0, 3'd0, 4'h0);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_sweep_busy", 32'(sweep_busy), 32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_pen_drop", 32'(pen_drop), 32'd0);
    check("rst_host_ack", 32'(host_ack), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_bus", 32'({ram_row, ram_col, ram_wdata}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill sweep with 0xA; pen strobe at idx 5, host request raised at idx 10.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back({3'(r), 3'(c), 4'hA});
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'hA;
    @(negedge clk);
    check("accept_cmd_ready", 32'(cmd_ready), 32'd1);
    check("accept_ram_we", 32'(ram_we), 32'd0);
    next_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 5) set_pen(1'b1, 3'd3, 3'd4, 4'hC);
      else        set_pen(1'b0, 3'd0, 3'd0, 4'h0);
      if (i == 10) set_host(1'b1, 3'd1, 3'd2, 4'h5);
      @(negedge clk);
      exp_w = exp_q.pop_front();
      check("fill_ram_we", 32'(ram_we), 32'd1);
      check("fill_bus", 32'({ram_row, ram_col, ram_wdata}), 32'(exp_w));
      check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
      check("fill_busy", 32'(sweep_busy), 32'd1);
      check("fill_host_ack", 32'(host_ack), 32'd0);
      check("fill_pen_drop", 32'(pen_drop), (i == 5) ? 32'd1 : 32'd0);
      check("fill_done_low", 32'(sweep_done), 32'd0);
      next_cycle();
    end
    set_pen(1'b0, 3'd0, 3'd0, 4'h0);
    @(negedge clk);
    check("done_pulse", 32'(sweep_done), 32'd1);
    check("done_cmd_ready", 32'(cmd_ready), 32'd0);
    check("done_host_ack", 32'(host_ack), 32'd1);
    check("done_host_bus", 32'({ram_we, ram_row, ram_col, ram_wdata}),
          32'({1'b1, 3'd1, 3'd2, 4'h5}));
    next_cycle();
    set_host(1'b0, 3'd0, 3'd0, 4'h0);
    @(negedge clk);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_done_low", 32'(sweep_done), 32'd0);
    check("post_ram_we", 32'(ram_we), 32'd0);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (ram_mem[k] !== ((k == 10) ? 4'h5 : 4'hA)) bad++;
    check("fill_cells_bad", 32'(bad), 32'd0);
    check("dropped_pen_cell", 32'(ram_mem[28]), 32'hA);

    // Pen write in IDLE goes straight to the RAM.
    next_cycle();
    set_pen(1'b1, 3'd3, 3'd4, 4'hC);
    @(negedge clk);
    check("idle_pen_bus", 32'({ram_we, ram_row, ram_col, ram_wdata}),
          32'({1'b1, 3'd3, 3'd4, 4'hC}));
    check("idle_pen_drop", 32'(pen_drop), 32'd0);
    next_cycle();
    set_pen(1'b0, 3'd0, 3'd0, 4'h0);
    check("idle_pen_cell", 32'(ram_mem[28]), 32'hC);

    // Pen and host collide: pen first, host the following cycle.
    set_pen(1'b1, 3'd6, 3'd1, 4'h3);
    set_host(1'b1, 3'd7, 3'd7, 4'h9);
    @(negedge clk);
    check("coll_pen_bus", 32'({ram_we, ram_row, ram_col, ram_wdata}),
          32'({1'b1, 3'd6, 3'd1, 4'h3}));
    check("coll_host_wait", 32'(host_ack), 32'd0);
    next_cycle();
    set_pen(1'b0, 3'd0, 3'd0, 4'h0);
    @(negedge clk);
    check("coll_host_ack", 32'(host_ack), 32'd1);
    check("coll_host_bus", 32'({ram_we, ram_row, ram_col, ram_wdata}),
          32'({1'b1, 3'd7, 3'd7, 4'h9}));
    next_cycle();
    set_host(1'b0, 3'd0, 3'd0, 4'h0);
    @(negedge clk);
    check("coll_idle_ack", 32'(host_ack), 32'd0);
    check("coll_idle_we", 32'(ram_we), 32'd0);
    check("coll_cells", 32'({ram_mem[49], ram_mem[63]}), 32'h39);

    // Preload (2,5)=E through the pen path, then invert the frame.
    next_cycle();
    set_pen(1'b1, 3'd2, 3'd5, 4'hE);
    next_cycle();
    set_pen(1'b0, 3'd0, 3'd0, 4'h0);
    for (int k = 0; k < 64; k++) snap[k] = ram_mem[k];
    check("preload_cell", 32'(snap[21]), 32'hE);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    next_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("inv_ram_we", 32'(ram_we), 32'd1);
      check("inv_wdata", 32'(ram_wdata), 32'(snap[i] ^ 4'h8));
      if (i == 21)
        check("inv_cell_2_5", 32'({ram_row, ram_col, ram_wdata}),
              32'({3'd2, 3'd5, 4'h6}));
      next_cycle();
    end
    @(negedge clk);
    check("inv_done", 32'(sweep_done), 32'd1);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (ram_mem[k] !== (snap[k] ^ 4'h8)) bad++;
    check("inv_cells_bad", 32'(bad), 32'd0);

    // Clear sweep aborted by reset while idx=20 is on the port.
    next_cycle();
    cmd_valid = 1'b1; cmd_op = 2'b00;
    next_cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      check("clr_bus", 32'({ram_we, ram_row, ram_col, ram_wdata}),
            32'({1'b1, 3'(i / 8), 3'(i % 8), 4'h0}));
      if (i < 20) next_cycle();
    end
    #1 rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_busy", 32'(sweep_busy), 32'd0);
    check("abort_ram_we", 32'(ram_we), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(sweep_done), 32'd0);
      check("abort_idle_ready", 32'(cmd_ready), 32'd1);
      next_cycle();
    end
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (ram_mem[k] !== ((k < 20) ? 4'h0 : (snap[k] ^ 4'h8))) bad++;
    check("abort_cells_bad", 32'(bad), 32'd0);

    // A fresh command restarts at idx 0 and runs the full 64 writes.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'h3;
    next_cycle();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("restart_first", 32'({ram_we, ram_row, ram_col, ram_wdata}),
          32'({1'b1, 3'd0, 3'd0, 4'h3}));
    cnt = 1;
    while (!sweep_done && cnt < 100) begin
      next_cycle();
      @(negedge clk);
      cnt++;
    end
    check("restart_len", 32'(cnt), 32'd65);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_ram_wr_sched.md
Name: led_ram_wr_sched

Overview:
Write-port scheduler for the 8x8 LED display RAM (4-bit cells: bit3 = lit, bits2:1 = colour, bit0 = spare).
- Shares the single RAM write port between three sources:
  - the light-pen write path;
  - a host write port with a req/ack handshake;
  - an internal sweep engine that clears, fills or inverts the whole frame on command.
- Sits between the LED driver/state logic and the display RAM, and replaces the direct pen-to-RAM write connection.

Parameters:
DATA_W, 4, RAM cell width
IDX_W, 3, row/col index width (8x8 array)
OP_INV_MASK, 4'b1000, XOR mask applied to each cell by the invert sweep

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pen_we  in  1  single-cycle light-pen write strobe
pen_row  in  3  pen target row index
pen_col  in  3  pen target column index
pen_data  in  4  pen write data
host_req  in  1  host write request; held until host_ack
host_row  in  3  host target row, stable while host_req is high
host_col  in  3  host target column, stable while host_req is high
host_data  in  4  host write data
host_ack  out  1  one-cycle pulse in the cycle the host write is performed
cmd_valid  in  1  sweep command valid
cmd_op  in  2  sweep op: 00 clear, 01 fill with cmd_data, 10 invert, 11 reserved
cmd_data  in  4  fill value
cmd_ready  out  1  high when the sweep engine is idle
sweep_busy  out  1  high while the sweep engine owns the RAM port
sweep_done  out  1  one-cycle pulse after the last sweep write
pen_drop  out  1  one-cycle pulse when pen_we is discarded
ram_rdata  in  4  asynchronous RAM read of the cell at ram_row/ram_col
ram_we  out  1  RAM write enable
ram_row  out  3  RAM row index
ram_col  out  3  RAM column index
ram_wdata  out  4  RAM write data

Behaviour:
- Reset: rst_n is asynchronous and active-low. The FSM goes to IDLE, the sweep counter to 0 and the latched op/data to 0. Outputs during reset: cmd_ready=1, sweep_busy=0, sweep_done=0, pen_drop=0. host_ack, ram_we, ram_row, ram_col and ram_wdata follow the IDLE combinational mux (all 0 when pen_we and host_req are low).
- FSM states and transitions:
  - IDLE: cmd_ready=1. When cmd_valid=1, latch op and data. Op 00/01/10 goes to SWEEP; op 11 goes directly to DONE.
  - SWEEP: sweep_busy=1, cmd_ready=0. A 6-bit counter idx runs 0..63, with row=idx[5:3] and col=idx[2:0]. One write per cycle, ram_we=1.
    - Write data: clear writes 4'h0, fill writes the latched data, invert writes ram_rdata ^ OP_INV_MASK (read-modify-write in the same cycle).
    - After the write with idx=63, go to DONE and reset idx to 0. A full sweep is exactly 64 cycles.
  - DONE: lasts one cycle with sweep_done=1 and cmd_ready=0, then returns to IDLE. cmd_valid is ignored in DONE.
- Port mux: combinational, zero latency, fixed priority sweep > pen > host.
  - SWEEP state: the sweep engine owns the port. pen_we produces pen_drop=1 that cycle and no write. host_req waits with host_ack=0.
  - IDLE/DONE with pen_we=1: pen write goes out (ram_we=1, pen address and data). A pending host_req waits.
  - IDLE/DONE with pen_we=0 and host_req=1: host write goes out with host_ack=1 that cycle. The requester must drop host_req or present a new write in the next cycle; a held req issues another write.
  - Otherwise ram_we=0, and ram_row, ram_col and ram_wdata are 0.
- The cycle in which a command is accepted is an IDLE cycle, so a pen or host write in that cycle is still performed. The first sweep write (idx=0) happens in the next cycle.
- Reset asserted mid-sweep aborts the sweep: the remaining cells are left unwritten and no sweep_done is issued.
- Host starvation under continuous pen_we is permitted. Pen strobes are sparse by design.

Test Plan:
- Reset, then cmd_valid with op=01 and cmd_data=4'hA -> cmd_ready falls next cycle. 64 consecutive ram_we cycles, addresses (0,0)..(7,7) in row-major order, wdata=A. sweep_done pulses in cycle 65, cmd_ready=1 in cycle 66.
- RAM model preloaded with cell(2,5)=4'hE, invert op -> write to (2,5) with wdata=4'h6. Every cell ends up XORed with 8.
- pen_we with (3,4,4'hC) during SWEEP -> pen_drop=1, no write to (3,4). The same pen write in IDLE -> ram_we with (3,4,C) and pen_drop=0.
- pen_we and host_req in the same IDLE cycle -> the pen write wins and host_ack=0. Next cycle, with pen_we low, the host write happens with host_ack=1.
- host_req raised during SWEEP -> host_ack stays 0 through all 64 sweep cycles. The host write is granted in the DONE cycle.
- rst_n pulsed low at idx=20 of a clear sweep -> cmd_ready=1 immediately and no sweep_done. A new command then starts again at idx=0.
